demux_fifo_router: RTL and testbench
====================================

# demux_fifo_router

One-to-four demultiplexer carrying 64-bit words in the opposite direction to the registered 4:1 mux. Each word arrives on a single valid/ready input stream with a 2-bit destination. The block steers the word into a small per-lane FIFO, and each lane presents it on an independent valid/ready output stream. This lets four downstream consumers drain at their own rates without losing data or reordering within a lane.

## Interface
Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 2, entries per lane FIFO; power of two, ≥2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  input word offered.
- in_ready  output  1  block can accept the offered word this cycle.
- in_ctrl  input  2  destination lane: 2'b00→lane 0 … 2'b11→lane 3.
- in_data  input  WIDTH  input word.
- out_valid  output  4  bit i set when lane i holds a word.
- out_ready  input  4  bit i set when lane i's consumer takes the head word.
- out_data  output  4*WIDTH  lane i head word at bits [i*WIDTH +: WIDTH].
- lane_full  output  4  bit i set when lane i FIFO holds DEPTH words (status only).

## Operation
- Per-lane FIFO:
  - Write pointer and read pointer, each log2(DEPTH)+1 bits.
  - Count = wr_ptr − rd_ptr, modulo 2^(log2(DEPTH)+1).
  - empty = (count == 0); full = (count == DEPTH).
  - Pointers wrap naturally; the MSB distinguishes full from empty.
- Handshake rules:
  - in_ready = ~full[in_ctrl]. It is combinational from in_ctrl and lane state, and independent of in_valid.
  - Push to lane in_ctrl when in_valid & in_ready.
  - out_valid[i] = ~empty[i]. out_data lane i = storage[i][rd_ptr[i]], read directly from the register array.
  - Pop lane i when out_valid[i] & out_ready[i]. out_ready on an empty lane is ignored.
- Simultaneous events:
  - Push and pop on the same non-full lane: both occur and the count is unchanged.
  - Push to a full lane: in_ready is low, so no push occurs, even if the same lane pops that cycle. There is no full-bypass path.
  - Pops on different lanes are independent and may all occur in one cycle.
- Ordering:
  - Words to the same lane leave in acceptance order.
  - No ordering guarantee across lanes.
- Rules for the producer and consumers:
  - in_data and in_ctrl must be held while in_valid is high and in_ready is low.
  - A lane never drops out_valid until its head word is popped.
  - in_ctrl may change between transfers. in_ready follows the newly selected lane in the same cycle.
- Reset:
  - Effective immediately on rst_n low, including mid-transfer.
  - All pointers are set to 0, so every lane is empty and all words in flight are discarded.
  - Storage is cleared to 0.
  - During reset: out_valid = 4'b0000, out_data = 0, lane_full = 4'b0000, in_ready = 1.
  - Transfers resume on the first rising edge after rst_n deasserts.

## Timing
- Latency: a word accepted at edge N shows out_valid high after edge N and is poppable in cycle N+1 at the earliest.
- Throughput: one input word per cycle, sustained while the target lane is not full.
- Each lane can output one word per cycle.
- Full lane with the consumer stalled: in_ready to that lane stays low until the cycle after the pop edge.
- No combinational path from out_ready to in_ready.
- Combinational paths:
  - in_ctrl → in_ready.
  - Register → out_valid / out_data / lane_full.

## Structure
- Shared package demux_pkg:
  - NUM_LANES = 4.
  - Lane-index typedef, 2 bits.
  - Pointer-width function clog2(DEPTH)+1.
- Sub-module demux_lane_fifo, instantiated four times:
  - Synchronous FIFO with push, pop, head data, empty and full.
  - Parameters WIDTH and DEPTH; async active-low reset.
- Top level:
  - Decodes in_ctrl into a one-hot push vector.
  - Muxes the selected full flag onto in_ready.
  - Packs the lane outputs onto out_data.

## Test plan
- **Reset mid-traffic.** Fill lane 2 with two words, then pulse rst_n low mid-cycle → out_valid immediately drops to 4'b0000, out_data to 0 and in_ready to 1; no old word reappears after release.
- **Basic steering.** With all out_ready = 1, send in_ctrl = 0, 1, 2, 3 carrying 0x1111…, 0x2222…, 0x3333…, 0x4444… on consecutive cycles → each value appears only on its lane, one cycle after acceptance, and never on another lane.
- **Full lane backpressure.**
  - With out_ready[1] = 0, send three words to lane 1 (DEPTH = 2) → lane_full[1] sets after the second; in_ready is low for the third.
  - Switching in_ctrl to 0 raises in_ready in the same cycle.
- **Pop and push on a full lane.** With lane 3 full (0xA, 0xB) and out_ready[3] = 1 while a third word 0xC is offered → 0xA pops and 0xC is not accepted that cycle; 0xC is accepted the next cycle and the output order is 0xA, 0xB, 0xC.
- **Wrap-around.** Push 10 sequential values 0…9 through lane 0 with a random out_ready pattern → all 10 arrive in order with none lost or duplicated across pointer wraps.
- **Parallel drain.** With every lane holding two words, assert out_ready = 4'b1111 for two cycles → all eight words pop in two cycles and out_valid returns to 4'b0000.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared lane count, lane index type and pointer sizing for the demux router
package demux_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_idx_t;

  // One extra pointer bit separates the full and empty cases when the pointers are equal modulo DEPTH
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_lane_fifo.sv
// rtl/demux_lane_fifo.sv - per-lane synchronous FIFO with a registered storage array and wrap-bit pointers
module demux_lane_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    w_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (w_count == '0);
  assign o_full    = (w_count == PW'(DEPTH));
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_fifo_router.sv
// rtl/demux_fifo_router.sv - steers one valid/ready input stream into four independently drained lane FIFOs
module demux_fifo_router
  import demux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  lane_idx_t                  in_ctrl,
  input  logic [WIDTH-1:0]           in_data,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]       lane_full
);

  logic [NUM_LANES-1:0] w_push;
  logic [NUM_LANES-1:0] w_pop;
  logic [NUM_LANES-1:0] w_empty;
  logic [NUM_LANES-1:0] w_full;

  // Ready depends only on the selected lane's full flag, so a same-cycle pop never frees the slot
  assign in_ready  = ~w_full[in_ctrl];
  assign out_valid = ~w_empty;
  assign lane_full = w_full;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_push = '0;
    if (in_valid && in_ready) begin
      w_push[in_ctrl] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_lane_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push[g]),
      .i_data (in_data),
      .i_pop  (w_pop[g]),
      .o_data (out_data[g*WIDTH +: WIDTH]),
      .o_empty(w_empty[g]),
      .o_full (w_full[g])
    );
  end

endmodule

// File: tb/tb_demux_fifo_router.sv
// tb/tb_demux_fifo_router.sv - randomized scenario bench for demux_fifo_router against a queue-based lane model
module tb_demux_fifo_router;

  localparam int W = 64;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_ctrl = 2'd0;
  logic [W-1:0] in_data = '0;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = 4'b0;
  logic [4*W-1:0] out_data;
  logic [3:0]   lane_full;

  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0] mq [4][$];

  demux_fifo_router #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .lane_full(lane_full)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (mq[i].size() > 0);
    return v;
  endfunction

  function automatic logic [3:0] exp_full();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (mq[i].size() == D);
    return f;
  endfunction

  function automatic logic [W-1:0] lane_data(input int i);
    return out_data[i*W +: W];
  endfunction

  // Drives one cycle from a negedge, updates the model with the pre-edge rules, returns at the next negedge
  task automatic drive_cycle(input bit v, input logic [1:0] c, input logic [W-1:0] d,
                             input logic [3:0] r, output bit acc);
    logic [3:0] pops;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = r;
    acc  = v && (mq[c].size() < D);
    pops = r & exp_valid();
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (pops[i]) void'(mq[i].pop_front());
    if (acc) mq[c].push_back(d);
    @(negedge clk);
  endtask

  task automatic idle_cycle(input logic [3:0] r);
    bit a;
    drive_cycle(1'b0, 2'd0, '0, r, a);
  endtask

  task automatic test_reset();
    bit a;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0000", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_cmp++; if (lane_full !== 4'b0) begin n_fail++; $display("FAIL reset_full got %b want 0000", lane_full); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    drive_cycle(1'b1, 2'd2, 64'hDEAD_0000_0000_0001, 4'b0, a);
    drive_cycle(1'b1, 2'd2, 64'hDEAD_0000_0000_0002, 4'b0, a);
    n_cmp++; if (out_valid !== 4'b0100 || lane_full !== 4'b0100) begin
      n_fail++; $display("FAIL reset_fill got v=%b f=%b want 0100/0100", out_valid, lane_full); end
    in_ctrl = 2'd2; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) mq[i].delete();
    n_cmp++; if (out_valid !== 4'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid got v=%b d=%h r=%b want 0000/0/1", out_valid, out_data, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle_cycle(4'b0);
    n_cmp++; if (out_valid !== 4'b0 || out_data !== '0) begin
      n_fail++; $display("FAIL reset_release got v=%b d=%h want 0000/0", out_valid, out_data); end
  endtask

  task automatic test_steering();
    bit a;
    logic [W-1:0] pat [4];
    pat[0] = {16{4'h1}}; pat[1] = {16{4'h2}}; pat[2] = {16{4'h3}}; pat[3] = {16{4'h4}};
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 2'(k), pat[k], 4'b1111, a);
      n_cmp++; if (out_valid !== (4'b1 << k) || lane_data(k) !== pat[k]) begin
        n_fail++; $display("FAIL steer_%0d got v=%b d=%h want %b/%h", k, out_valid, lane_data(k), 4'b1 << k, pat[k]); end
    end
    idle_cycle(4'b1111);
    n_cmp++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL steer_drain got %b want 0000", out_valid); end
  endtask

  task automatic test_backpressure();
    bit a;
    drive_cycle(1'b1, 2'd1, 64'hB1, 4'b0, a);
    n_cmp++; if (lane_full[1] !== 1'b0) begin n_fail++; $display("FAIL bp_full_early got %b want 0", lane_full[1]); end
    drive_cycle(1'b1, 2'd1, 64'hB2, 4'b0, a);
    n_cmp++; if (lane_full !== exp_full() || lane_full[1] !== 1'b1) begin
      n_fail++; $display("FAIL bp_full got %b want %b", lane_full, exp_full()); end
    in_valid = 1'b1; in_ctrl = 2'd1; in_data = 64'hB3; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got %b want 0", in_ready); end
    in_ctrl = 2'd0; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_switch got %b want 1", in_ready); end
    drive_cycle(1'b1, 2'd0, 64'hA0, 4'b0, a);
    n_cmp++; if (out_valid !== exp_valid() || lane_data(1) !== mq[1][0] || lane_data(0) !== mq[0][0]) begin
      n_fail++; $display("FAIL bp_heads got v=%b d1=%h d0=%h want %b", out_valid, lane_data(1), lane_data(0), exp_valid()); end
    for (int k = 0; k < 3; k++) idle_cycle(4'b1111);
    n_cmp++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0000", out_valid); end
  endtask

  task automatic test_pop_push_full();
    bit a;
    drive_cycle(1'b1, 2'd3, 64'hA, 4'b0, a);
    drive_cycle(1'b1, 2'd3, 64'hB, 4'b0, a);
    in_valid = 1'b1; in_ctrl = 2'd3; in_data = 64'hC; out_ready = 4'b1000; #1;
    n_cmp++; if (in_ready !== 1'b0 || lane_data(3) !== 64'hA) begin
      n_fail++; $display("FAIL ppf_first got r=%b d=%h want 0/a", in_ready, lane_data(3)); end
    drive_cycle(1'b1, 2'd3, 64'hC, 4'b1000, a);
    n_cmp++; if (a || lane_data(3) !== 64'hB || lane_full[3] !== 1'b0) begin
      n_fail++; $display("FAIL ppf_second got d=%h f=%b want b/0", lane_data(3), lane_full[3]); end
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ppf_ready got %b want 1", in_ready); end
    drive_cycle(1'b1, 2'd3, 64'hC, 4'b1000, a);
    n_cmp++; if (!a || lane_data(3) !== 64'hC || out_valid[3] !== 1'b1) begin
      n_fail++; $display("FAIL ppf_third got d=%h v=%b want c/1", lane_data(3), out_valid[3]); end
    idle_cycle(4'b1000);
    n_cmp++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL ppf_drain got %b want 0000", out_valid); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] got [$];
    logic [3:0] r;
    int sent = 0;
    int cyc = 0;
    bit a;
    while (got.size() < 10 && cyc < 200) begin
      r = {3'b0, 1'($urandom_range(0, 1))};
      if (r[0] && out_valid[0]) got.push_back(lane_data(0));
      drive_cycle(sent < 10, 2'd0, W'(sent), r, a);
      if (a) sent++;
      cyc++;
    end
    n_cmp++; if (got.size() != 10) begin n_fail++; $display("FAIL wrap_count got %0d want 10", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      n_cmp++; if (got[k] !== W'(k)) begin n_fail++; $display("FAIL wrap_order_%0d got %h want %h", k, got[k], W'(k)); end
    end
  endtask

  task automatic test_parallel_drain();
    bit a;
    for (int k = 0; k < 8; k++) drive_cycle(1'b1, 2'(k % 4), {$urandom, $urandom}, 4'b0, a);
    n_cmp++; if (lane_full !== 4'b1111 || out_valid !== 4'b1111) begin
      n_fail++; $display("FAIL pd_full got f=%b v=%b want 1111/1111", lane_full, out_valid); end
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (lane_data(i) !== mq[i][0]) begin
          n_fail++; $display("FAIL pd_head_%0d_%0d got %h want %h", c, i, lane_data(i), mq[i][0]); end
      end
      idle_cycle(4'b1111);
    end
    n_cmp++; if (out_valid !== 4'b0) begin n_fail++; $display("FAIL pd_empty got %b want 0000", out_valid); end
  endtask

  task automatic test_random();
    bit a;
    bit v = 1'b0;
    logic [1:0] c = 2'd0;
    logic [W-1:0] d = '0;
    logic [3:0] r;
    for (int n = 0; n < 400; n++) begin
      if (!(v && mq[c].size() == D)) begin
        v = 1'($urandom_range(0, 3) != 0);
        c = 2'($urandom_range(0, 3));
        d = {$urandom, $urandom};
      end
      r = 4'($urandom);
      in_valid = v; in_ctrl = c; in_data = d; out_ready = r; #1;
      n_cmp++; if (in_ready !== (mq[c].size() < D) || out_valid !== exp_valid() || lane_full !== exp_full()) begin
        n_fail++; $display("FAIL rand_ctl_%0d got r=%b v=%b f=%b want %b/%b/%b", n, in_ready, out_valid, lane_full,
                           mq[c].size() < D, exp_valid(), exp_full()); end
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() > 0) begin
          n_cmp++; if (lane_data(i) !== mq[i][0]) begin
            n_fail++; $display("FAIL rand_head_%0d_%0d got %h want %h", n, i, lane_data(i), mq[i][0]); end
        end
      end
      drive_cycle(v, c, d, r, a);
      if (a) v = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_steering();
    test_backpressure();
    test_pop_push_full();
    test_wrap();
    for (int k = 0; k < 4; k++) idle_cycle(4'b1111);
    test_parallel_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
